// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refill and data port.
// Define MEM_ARB_TIMEOUT_EN to abort grants that see no i_MEM_ready within TIMEOUT_CYCLES.
module mem_port_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_IC_DataReq,
    input  logic [XLEN-1:0] i_IC_Addr,
    output logic            o_IC_MemReady,
    output logic [XLEN-1:0] o_IC_DataBlock,
    input  logic            i_DM_MemRead,
    input  logic            i_DM_Wen,
    input  logic [XLEN-1:0] i_DM_Addr,
    input  logic [XLEN-1:0] i_DM_Wd,
    input  logic [2:0]      i_DM_f3,
    output logic            o_DM_data_ready,
    output logic [XLEN-1:0] o_DM_ReadData,
    output logic [XLEN-1:0] o_MEM_Addr,
    output logic [XLEN-1:0] o_MEM_Wd,
    output logic [2:0]      o_MEM_f3,
    output logic            o_MEM_Wen,
    output logic            o_MEM_Ren,
    input  logic            i_MEM_ready,
    input  logic [XLEN-1:0] i_MEM_ReadData,
    output logic            o_IC_err,
    output logic            o_DM_err,
    output logic            o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wd_q, wd_d;
    logic [2:0]        f3_q, f3_d;
    logic              wen_q, wen_d;
    logic              d_req, i_req;
    logic              done, tmo, rd_ok;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    assign d_req  = i_DM_MemRead | i_DM_Wen;
    assign i_req  = i_IC_DataReq;
    assign o_busy = (state_q != IDLE);

    always_comb begin
        state_d         = state_q;
        last_d_d        = last_d_q;
        addr_d          = addr_q;
        wd_d            = wd_q;
        f3_d            = f3_q;
        wen_d           = wen_q;
        done            = 1'b0;
        tmo             = 1'b0;
        rd_ok           = 1'b0;
        o_MEM_Addr      = '0;
        o_MEM_Wd        = '0;
        o_MEM_f3        = '0;
        o_MEM_Wen       = 1'b0;
        o_MEM_Ren       = 1'b0;
        o_IC_MemReady   = 1'b0;
        o_IC_DataBlock  = '0;
        o_DM_data_ready = 1'b0;
        o_DM_ReadData   = '0;
        o_IC_err        = 1'b0;
        o_DM_err        = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d           = '0;
`endif
        unique case (state_q)
            IDLE: begin
                // D wins a conflict unless it held the previous grant
                if (d_req && (!i_req || !last_d_q)) begin
                    state_d  = GNT_D;
                    last_d_d = 1'b1;
                    addr_d   = i_DM_Addr;
                    wd_d     = i_DM_Wd;
                    f3_d     = i_DM_f3;
                    wen_d    = i_DM_Wen;
                end else if (i_req) begin
                    state_d  = GNT_I;
                    last_d_d = 1'b0;
                    addr_d   = i_IC_Addr;
                    wd_d     = '0;
                    f3_d     = 3'b010;
                    wen_d    = 1'b0;
                end
            end
            GNT_I, GNT_D: begin
                o_MEM_Addr = addr_q;
                o_MEM_Wd   = wd_q;
                o_MEM_f3   = f3_q;
                o_MEM_Wen  = wen_q;
                o_MEM_Ren  = !wen_q;
`ifdef MEM_ARB_TIMEOUT_EN
                tmo   = !i_MEM_ready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
                cnt_d = cnt_q + 1'b1;
`endif
                done  = (i_MEM_ready || tmo) && !i_rst;
                rd_ok = i_MEM_ready && !i_rst;
                if (i_MEM_ready || tmo) begin
                    state_d = IDLE;
                end
                if (state_q == GNT_I) begin
                    o_IC_MemReady  = done;
                    o_IC_err       = tmo && !i_rst;
                    o_IC_DataBlock = rd_ok ? i_MEM_ReadData : '0;
                end else begin
                    o_DM_data_ready = done;
                    o_DM_err        = tmo && !i_rst;
                    o_DM_ReadData   = rd_ok ? i_MEM_ReadData : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
            f3_q     <= '0;
            wen_q    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            f3_q     <= f3_d;
            wen_q    <= wen_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural memory with programmable latency,
// expected completions queued at stimulus time and popped on each ready pulse.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ic_req;
    logic [XLEN-1:0] ic_addr;
    logic            ic_rdy;
    logic [XLEN-1:0] ic_data;
    logic            dm_rd;
    logic            dm_wen;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wd;
    logic [2:0]      dm_f3;
    logic            dm_rdy;
    logic [XLEN-1:0] dm_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wd;
    logic [2:0]      mem_f3;
    logic            mem_wen;
    logic            mem_ren;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;
    logic            ic_err;
    logic            dm_err;
    logic            busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_IC_DataReq(ic_req), .i_IC_Addr(ic_addr),
        .o_IC_MemReady(ic_rdy), .o_IC_DataBlock(ic_data),
        .i_DM_MemRead(dm_rd), .i_DM_Wen(dm_wen), .i_DM_Addr(dm_addr),
        .i_DM_Wd(dm_wd), .i_DM_f3(dm_f3),
        .o_DM_data_ready(dm_rdy), .o_DM_ReadData(dm_data),
        .o_MEM_Addr(mem_addr), .o_MEM_Wd(mem_wd), .o_MEM_f3(mem_f3),
        .o_MEM_Wen(mem_wen), .o_MEM_Ren(mem_ren),
        .i_MEM_ready(mem_ready), .i_MEM_ReadData(mem_rdata),
        .o_IC_err(ic_err), .o_DM_err(dm_err), .o_busy(busy)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t sbq[$];
    exp_t got_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_f(logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    function automatic exp_t mk(bit is_d, logic [31:0] data, bit err);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.err  = err;
        return e;
    endfunction

    // memory answers in the mem_lat-th strobe cycle when enabled
    int  mem_lat  = 1;
    bit  mem_en   = 1'b1;
    bit  mem_poke = 1'b0;
    int  mcnt     = 0;
    wire strobe   = mem_ren | mem_wen;

    assign mem_ready = mem_poke | (mem_en && strobe && (mcnt == mem_lat - 1));
    assign mem_rdata = mem_ready ? mem_f(mem_addr) : '0;

    always @(posedge clk) mcnt <= (!strobe || mem_ready) ? 0 : mcnt + 1;

    always @(negedge clk) begin
        if (ic_rdy || dm_rdy) begin
            if (sbq.size() == 0) begin
                check("unexpected_ready", {ic_rdy, dm_rdy}, 2'b00);
            end else begin
                got_e = sbq.pop_front();
                check("ready_port", {dm_rdy, ic_rdy}, got_e.is_d ? 2'b10 : 2'b01);
                check("ready_data", got_e.is_d ? dm_data : ic_data, got_e.data);
                check("ready_err", got_e.is_d ? dm_err : ic_err, got_e.err);
            end
        end else if (ic_err || dm_err) begin
            check("stray_err", {ic_err, dm_err}, 2'b00);
        end
    end

    task automatic wait_ready(string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = ic_rdy || dm_rdy;
        end
        check(tag, seen, 1'b1);
    endtask

    initial begin
        rst     = 1'b1;
        ic_req  = 1'b1;
        ic_addr = 32'h300;
        dm_rd   = 1'b1;
        dm_wen  = 1'b0;
        dm_addr = 32'h400;
        dm_wd   = '0;
        dm_f3   = 3'b010;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ren", mem_ren, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_rdy", {ic_rdy, dm_rdy}, 0);
        check("rst_err", {ic_err, dm_err}, 0);

        // both held high: D, I, D, I with an IDLE bubble between each
        sbq.push_back(mk(1, mem_f(32'h400), 0));
        sbq.push_back(mk(0, mem_f(32'h300), 0));
        sbq.push_back(mk(1, mem_f(32'h400), 0));
        sbq.push_back(mk(0, mem_f(32'h300), 0));
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1 ic_req = 1'b0; dm_rd = 1'b0;
        @(negedge clk);
        check("rr_drained", sbq.size(), 0);
        check("rr_idle", busy, 0);

        @(posedge clk); #1 mem_poke = 1'b1;
        @(negedge clk);
        check("poke_busy", busy, 0);
        check("poke_rdy", {ic_rdy, dm_rdy}, 0);
        @(posedge clk); #1 mem_poke = 1'b0;

        mem_lat = 3;
        sbq.push_back(mk(0, 32'hDEADBEEF, 0));
        ic_req  = 1'b1;
        ic_addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("ic_ren", mem_ren, 1);
            check("ic_wen", mem_wen, 0);
            check("ic_addr", mem_addr, 32'h100);
            check("ic_f3", mem_f3, 3'b010);
            check("ic_rdy", ic_rdy, (i == 2));
            check("ic_dm_rdy", dm_rdy, 0);
        end
        @(posedge clk); #1 ic_req = 1'b0;
        @(negedge clk);
        check("ic_done", sbq.size(), 0);

        mem_lat = 2;
        sbq.push_back(mk(1, mem_f(32'h2004), 0));
        dm_wen  = 1'b1;
        dm_rd   = 1'b1;
        dm_addr = 32'h2004;
        dm_wd   = 32'h55;
        dm_f3   = 3'b001;
        @(posedge clk);
        @(negedge clk);
        check("wr_wen", mem_wen, 1);
        check("wr_ren", mem_ren, 0);
        check("wr_addr", mem_addr, 32'h2004);
        check("wr_wd", mem_wd, 32'h55);
        check("wr_f3", mem_f3, 3'b001);
        @(posedge clk);
        #1 dm_addr = 32'h3000; dm_wd = 32'hAA; dm_f3 = 3'b101; dm_wen = 1'b0;
        @(negedge clk);
        check("latch_addr", mem_addr, 32'h2004);
        check("latch_wd", mem_wd, 32'h55);
        check("latch_wen", mem_wen, 1);
        @(posedge clk); #1 dm_rd = 1'b0;
        @(negedge clk);
        check("wr_done", sbq.size(), 0);

        ic_req  = 1'b1;
        ic_addr = 32'h500;
        @(posedge clk);
        @(negedge clk);
        check("mr_ren", mem_ren, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("mr_no_rdy", ic_rdy, 0);
        @(posedge clk); #1 rst = 1'b0; ic_req = 1'b0;
        @(negedge clk);
        check("mr_busy", busy, 0);
        check("mr_ren0", mem_ren, 0);
        check("mr_addr0", mem_addr, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        mem_en = 1'b0;
        sbq.push_back(mk(0, 32'h0, 1));
        ic_req  = 1'b1;
        ic_addr = 32'h600;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("to_ren", mem_ren, 1);
            check("to_err", ic_err, (i == 3));
        end
        @(posedge clk); #1 ic_req = 1'b0;
        @(negedge clk);
        check("to_busy", busy, 0);
        mem_en  = 1'b1;
        mem_lat = 4;
        sbq.push_back(mk(0, mem_f(32'h600), 0));
        @(posedge clk); #1 ic_req = 1'b1;
        wait_ready("to_ready_wins");
        @(posedge clk); #1 ic_req = 1'b0;
`else
        mem_lat = 1;
        sbq.push_back(mk(1, mem_f(32'h700), 0));
        dm_rd   = 1'b1;
        dm_addr = 32'h700;
        dm_f3   = 3'b100;
        wait_ready("dm_read");
        @(posedge clk); #1 dm_rd = 1'b0;
`endif

        @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-cache refill port and the data-memory port of one hart.
- Sits between the core (I_CACHE miss interface, DATA_MEMORY_V2 bus interface) and the system memory/bus.
- Registered-grant FSM with round-robin arbitration. One transaction is outstanding at a time.
- Request fields are latched at grant, so the memory sees stable strobes for the whole transaction.

Parameters:
- XLEN, `XLEN (32): address/data width.
- TIMEOUT_CYCLES, 256: cycles in a grant state before abort. Used only with MEM_ARB_TIMEOUT_EN; must be >= 2.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_IC_DataReq  in  1  instruction refill request, level, held until o_IC_MemReady
- i_IC_Addr  in  XLEN  instruction refill address
- o_IC_MemReady  out  1  one-cycle completion pulse to I-cache
- o_IC_DataBlock  out  XLEN  refill data, valid with o_IC_MemReady
- i_DM_MemRead  in  1  data read request, level
- i_DM_Wen  in  1  data write request, level
- i_DM_Addr  in  XLEN  data address
- i_DM_Wd  in  XLEN  write data
- i_DM_f3  in  3  access size/sign (funct3)
- o_DM_data_ready  out  1  one-cycle completion pulse to data port
- o_DM_ReadData  out  XLEN  read data, valid with o_DM_data_ready
- o_MEM_Addr  out  XLEN  memory address
- o_MEM_Wd  out  XLEN  memory write data
- o_MEM_f3  out  3  memory access size
- o_MEM_Wen  out  1  memory write strobe
- o_MEM_Ren  out  1  memory read strobe
- i_MEM_ready  in  1  memory completion, one cycle
- i_MEM_ReadData  in  XLEN  memory read data
- o_IC_err, o_DM_err  out  1  timeout abort flags (see Optional Feature)
- o_busy  out  1  high when the FSM is not in IDLE

Behaviour:
- States: IDLE, GNT_I, GNT_D. Reset: state=IDLE, last_grant=I (so D wins the first conflict). All outputs and latches are 0.
- In IDLE:
  - D request = i_DM_MemRead | i_DM_Wen; I request = i_IC_DataReq.
  - Only one requesting: grant it.
  - Both requesting: grant the one not equal to last_grant.
  - On grant, latch addr/wd/f3/type, update last_grant, and move to GNT_x at the next edge.
  - No request: stay in IDLE.
- In GNT_I:
  - o_MEM_Ren=1, o_MEM_Wen=0.
  - o_MEM_Addr = latched I address; o_MEM_f3 = 3'b010; o_MEM_Wd = 0.
- In GNT_D:
  - If latched i_DM_Wen=1: o_MEM_Wen=1, o_MEM_Ren=0. This applies even if MemRead was also set; write takes precedence.
  - Otherwise: o_MEM_Ren=1.
  - Addr/Wd/f3 come from the latches.
- Completion:
  - In GNT_x with i_MEM_ready=1, the matching ready output pulses the same cycle (combinational).
  - Read data passes through combinationally. The non-granted ready is 0 and its data output is 0.
  - Next state = IDLE. Strobes deassert the following cycle.
- Memory strobes and o_MEM_* are 0 in IDLE.
- Minimum latency: request in cycle 0 (IDLE), strobes in cycle 1, ready in cycle 1 if memory answers immediately. Back-to-back requests from the same requester are separated by one IDLE bubble.
- i_MEM_ready in IDLE is ignored.
- Requester deasserting its request mid-grant: the transaction still completes and the ready pulse is still issued.
- Request fields changing mid-grant: ignored, because they were latched.
- Reset mid-transaction: next edge forces IDLE and clears strobes, latches, last_grant and the timeout counter. No ready pulse is issued.
- o_busy = (state != IDLE).

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to GNT_x and increments each grant cycle without i_MEM_ready.
  - When the count reaches TIMEOUT_CYCLES-1 without ready, the granted o_x_ready and o_x_err pulse together for one cycle, with read data 0.
  - The FSM then returns to IDLE and strobes drop.
  - If i_MEM_ready and timeout coincide, ready wins and err=0.
- Without the macro: no counter; a grant waits indefinitely; o_IC_err and o_DM_err are tied 0.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles with both requests high -> all outputs 0, o_busy=0. After release, GNT_D is entered first.
- Single I read: i_IC_DataReq=1, i_IC_Addr=0x100, memory returns 0xDEADBEEF after 3 cycles -> o_MEM_Ren=1 with Addr=0x100 and f3=010 for 3 cycles, then o_IC_MemReady pulses with o_IC_DataBlock=0xDEADBEEF. o_DM_data_ready stays 0.
- Conflict and round-robin: I and D requests held high continuously, memory ready every cycle -> grant sequence D,I,D,I with one IDLE between transactions. Each ready pulses exactly once per grant.
- Write precedence: i_DM_Wen=1 and i_DM_MemRead=1, Addr=0x2004, Wd=0x55, f3=001 -> o_MEM_Wen=1, o_MEM_Ren=0, o_MEM_Addr=0x2004, o_MEM_Wd=0x55, o_MEM_f3=001.
- Latch and mid-reset: change i_DM_Addr during GNT_D -> o_MEM_Addr unchanged. Assert i_rst during GNT_I -> next cycle IDLE, strobes 0, no ready pulse.
- Timeout (macro on, TIMEOUT_CYCLES=4): I request, memory never ready -> strobes high for 4 cycles, o_IC_MemReady=o_IC_err=1 on the 4th, IDLE next. Repeat with ready arriving on the 4th cycle -> err=0.
